// File: rtl/johnson_counter.sv
// Johnson (twisted-ring) counter with phase decode, terminal-count flag and
// recovery from illegal states. q is flop-driven; phase and tc decode q.
module johnson_counter #(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic [PW-1:0]    phase,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] LAST_W = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [31:0]      PERIOD = 32'(2 * WIDTH);

    // True when v is a run of ones anchored at the LSB (including zero):
    // adding one carries out of the whole run and clears every set bit.
    function automatic logic is_thermo(input logic [WIDTH-1:0] v);
        return ((v & (v + ONE_W)) == ZERO_W);
    endfunction

    // Legal states are 0..01..1 (MSB clear) or 1..10..0 (MSB set).
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic ok;
        if (v[WIDTH-1] == 1'b0) begin
            ok = is_thermo(v);
        end else begin
            ok = is_thermo(~v);
        end
        return ok;
    endfunction

    // Population count widened to 32 bits for the phase arithmetic.
    function automatic logic [31:0] ones_count(input logic [WIDTH-1:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic             legal_s;
    logic [31:0]      ones_s;
    logic [31:0]      phase_full_s;
    logic             tc_s;

    // Legality check and ones count of the current state.
    always_comb begin
        legal_s = is_legal(q_r);
        ones_s  = ones_count(q_r);
    end

    // Phase index: rising half counts ones, falling half counts down from 2*WIDTH.
    always_comb begin
        phase_full_s = 32'd0;
        if (legal_s == 1'b0) begin
            phase_full_s = 32'd0;
        end else if (q_r[WIDTH-1] == 1'b0) begin
            phase_full_s = ones_s;
        end else begin
            phase_full_s = PERIOD - ones_s;
        end
    end

    // Terminal count: last legal state before the wrap to all zeros.
    always_comb begin
        if (q_r == LAST_W) begin
            tc_s = 1'b1;
        end else begin
            tc_s = 1'b0;
        end
    end

    // State register: reset first, then illegal-state recovery, then twist-shift.
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            q_r <= ZERO_W;
        end else if (legal_s == 1'b0) begin
            q_r <= ZERO_W;
        end else begin
            q_r <= {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        end
    end

    assign q     = q_r;
    assign phase = phase_full_s[PW-1:0];
    assign tc    = tc_s;

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter: four widths share one clock and
// reset; a step-index model predicts q, phase and tc every cycle.
module tb_johnson_counter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] q4; logic [2:0] ph4; logic tc4;
    logic [1:0] q2; logic [1:0] ph2; logic tc2;
    logic [2:0] q3; logic [2:0] ph3; logic tc3;
    logic [7:0] q8; logic [3:0] ph8; logic tc8;

    johnson_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .q(q4), .phase(ph4), .tc(tc4));
    johnson_counter #(.WIDTH(2)) dut2 (.clk(clk), .reset(reset), .q(q2), .phase(ph2), .tc(tc2));
    johnson_counter #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .q(q3), .phase(ph3), .tc(tc3));
    johnson_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .q(q8), .phase(ph8), .tc(tc8));

    localparam int WS [4] = '{4, 2, 3, 8};

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: step index within the period, illegal-deposit flag,
    // and previous q for the one-bit-change property.
    int          s    [4];
    bit          ill  [4];
    bit          pok  [4];
    logic [31:0] pq   [4];
    bit          valid = 1'b0;

    logic [31:0] dq [4];
    logic [31:0] dp [4];
    logic [31:0] dt [4];

    // Gather the DUT outputs into width-neutral arrays.
    always_comb begin
        dq[0] = 32'(q4); dp[0] = 32'(ph4); dt[0] = 32'(tc4);
        dq[1] = 32'(q2); dp[1] = 32'(ph2); dt[1] = 32'(tc2);
        dq[2] = 32'(q3); dp[2] = 32'(ph3); dt[2] = 32'(tc3);
        dq[3] = 32'(q8); dp[3] = 32'(ph8); dt[3] = 32'(tc8);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Step s of a w-bit Johnson sequence: s ones filling from the LSB, then
    // zeros filling from the LSB once all bits are set.
    function automatic logic [31:0] exp_q(input int w, input int st);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        if (st <= w) return (32'd1 << st) - 32'd1;
        else         return mask & ~((32'd1 << (st - w)) - 32'd1);
    endfunction

    // Advance the model on each edge, then compare every instance.
    always @(posedge clk) begin
        logic r;
        r = reset;
        for (int i = 0; i < 4; i++) begin
            if (!r)          s[i] = 0;
            else if (ill[i]) s[i] = 0;
            else             s[i] = (s[i] + 1) % (2 * WS[i]);
            ill[i] = 1'b0;
        end
        if (!r) valid = 1'b1;
        #1;
        if (valid) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("q w%0d", WS[i]), dq[i], exp_q(WS[i], s[i]));
                check($sformatf("phase w%0d", WS[i]), dp[i], 32'(s[i]));
                check($sformatf("tc w%0d", WS[i]), dt[i], (s[i] == 2 * WS[i] - 1) ? 32'd1 : 32'd0);
                if (pok[i] && r)
                    check($sformatf("onebit w%0d", WS[i]), 32'($countones(pq[i] ^ dq[i])), 32'd1);
                pq[i]  = dq[i];
                pok[i] = 1'b1;
            end
        end
    end

    logic [3:0] lit4 [16];
    int pulses;

    initial begin
        lit4 = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0,
                 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        for (int i = 0; i < 4; i++) begin
            s[i] = 0; ill[i] = 1'b0; pok[i] = 1'b0; pq[i] = 32'd0;
        end

        // Reset then run
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset q", 32'(q4), 32'h0);
        check("reset phase", 32'(ph4), 32'd0);
        check("reset tc", 32'(tc4), 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #2;
            check("run q lit", 32'(q4), 32'(lit4[k]));
            check("run phase lit", 32'(ph4), 32'((k + 1) % 8));
        end

        // Terminal count over 24 free-running cycles
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #2;
            if (tc4) pulses++;
        end
        check("tc pulses", 32'(pulses), 32'd3);
        check("after tc run q", 32'(q4), 32'h0);

        // Mid-sequence reset
        repeat (3) @(posedge clk);
        #2 check("mid q 0111", 32'(q4), 32'h7);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #2 check("mid reset q", 32'(q4), 32'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #2 check("mid release q", 32'(q4), 32'h1);

        // Illegal-state recovery
        @(negedge clk);
        dut4.q_r = 4'b0101;
        ill[0] = 1'b1; pok[0] = 1'b0;
        #1;
        check("illegal q held", 32'(q4), 32'h5);
        check("illegal phase", 32'(ph4), 32'd0);
        check("illegal tc", 32'(tc4), 32'd0);
        @(posedge clk); #2 check("recover q", 32'(q4), 32'h0);
        @(posedge clk); #2 check("recover next q", 32'(q4), 32'h1);

        // Reset priority over an illegal state
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dut4.q_r = 4'b0101;
            ill[0] = 1'b1; pok[0] = 1'b0;
            reset = 1'b0;
            @(posedge clk); #2 check("prio q", 32'(q4), 32'h0);
        end

        // Long run covering the full WIDTH=8 period
        @(negedge clk) reset = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("w4 end q", 32'(q4), 32'hF);
        check("w8 end q", 32'(q8), 32'h0F);
        check("w8 end phase", 32'(ph8), 32'd4);
        check("w3 end q", 32'(q3), 32'h3);
        check("w2 end q", 32'(q2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
